// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : instruction-memory request/response bus (one outstanding)
// Rev 1.0
// ============================================================================
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : RV32 fetch front end - PC, imem request FSM, skid, ID registers
// Rev 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  wire         clk,
    input  wire         reset_n,
    fetch_stage_if.master imem,
    input  wire         redirect_valid,
    input  wire  [31:0] redirect_target,
    input  wire         stall,
    output logic [31:0] inst_ID,
    output logic        inst_valid_ID,
    output logic [31:0] PC_ID,
    output logic [31:0] PCplus4_ID
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_id_q, pc_id_d;

    logic        req_valid;
    logic        handshake;
    logic        rsp_accept;
    logic        hold_req;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        valid_d      = valid_q;
        inst_d       = inst_q;
        pc_id_d      = pc_id_q;
        req_valid    = 1'b0;
        handshake    = 1'b0;
        rsp_accept   = 1'b0;
        hold_req     = skid_valid_q || (stall && valid_q);

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                req_valid = !hold_req;
                handshake = req_valid && imem.imem_req_ready;
                if (handshake) begin
                    pc_d     = pc_q + 32'd4;
                    req_pc_d = pc_q;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    rsp_accept = !kill_q;
                    kill_d     = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // ID register update: a stalled valid instruction parks new data in the skid
        if (stall && valid_q) begin
            if (rsp_accept) begin
                skid_valid_d = 1'b1;
                skid_inst_d  = imem.imem_rsp_data;
                skid_pc_d    = req_pc_q;
            end
        end else if (skid_valid_q) begin
            valid_d      = 1'b1;
            inst_d       = skid_inst_q;
            pc_id_d      = skid_pc_q;
            skid_valid_d = 1'b0;
        end else if (rsp_accept) begin
            valid_d = 1'b1;
            inst_d  = imem.imem_rsp_data;
            pc_id_d = req_pc_q;
        end else begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
        end

        // A response arriving with the redirect is the outstanding one, so no kill
        if (redirect_valid) begin
            pc_d         = {redirect_target[31:2], 2'b00};
            skid_valid_d = 1'b0;
            valid_d      = 1'b0;
            inst_d       = NOP_INST;
            pc_id_d      = pc_id_q;
            kill_d       = handshake || ((state_q == S_WAIT) && !imem.imem_rsp_valid);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            kill_q       <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= NOP_INST;
            skid_pc_q    <= RESET_PC;
            valid_q      <= 1'b0;
            inst_q       <= NOP_INST;
            pc_id_q      <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            valid_q      <= valid_d;
            inst_q       <= inst_d;
            pc_id_q      <= pc_id_d;
        end
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc_q;
    assign inst_ID             = inst_q;
    assign inst_valid_ID       = valid_q;
    assign PC_ID               = pc_id_q;
    assign PCplus4_ID          = pc_id_q + 32'd4;

endmodule
`default_nettype wire
